// File: rtl/wbs_sdram_model_pkg.sv
// rtl/wbs_sdram_model_pkg.sv - shared widths and state encodings for the SDRAM stand-in slave
package wbs_sdram_model_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_REFRESH = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wbs_sdram_model_ack_pipe.sv
// rtl/wbs_sdram_model_ack_pipe.sv - fixed-latency delay line of {valid, read data} with synchronous flush
module wbs_sdram_model_ack_pipe #(
  parameter int LATENCY = 4,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] valid_q;
  logic [DATA_W-1:0]  data_q [LATENCY];

  // Flush only kills the valid bits; stale data is masked downstream by the valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid & ~flush;
      data_q[0]  <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1] & ~flush;
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/wbs_sdram_model.sv
// rtl/wbs_sdram_model.sv - pipelined Wishbone slave backing a small RAM with SDRAM-like stall behaviour
module wbs_sdram_model
  import wbs_sdram_model_pkg::*;
#(
  parameter int ADDR_W          = 10,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int INIT_STALL      = 100,
  parameter int REFRESH_PERIOD  = 780,
  parameter int REFRESH_LEN     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WB_ADDR_W-1:0] wbs_address,
  input  logic [WB_DATA_W-1:0] wbs_writedata,
  output logic [WB_DATA_W-1:0] wbs_readdata,
  input  logic                 wbs_strobe,
  input  logic                 wbs_cycle,
  input  logic                 wbs_write,
  output logic                 wbs_ack,
  output logic                 wbs_stall,
  output logic                 protocol_err
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int PEND_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [31:0] INIT_LAST = 32'((INIT_STALL > 0) ? INIT_STALL - 1 : 0);
  localparam logic [31:0] RUN_LAST  = 32'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
  localparam logic [31:0] REF_LAST  = 32'((REFRESH_LEN > 0) ? REFRESH_LEN - 1 : 0);

  wb_state_e             state;
  logic [31:0]           phase_cnt;
  logic [PEND_W-1:0]     pending;
  logic [WB_DATA_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]     idx;
  logic                  accept;
  logic                  pipe_valid;
  logic [WB_DATA_W-1:0]  pipe_data;
  logic [WB_DATA_W-1:0]  capture_data;
  logic                  unused_addr_bits;

  assign idx              = wbs_address[ADDR_W-1:0];
  assign unused_addr_bits = ^wbs_address[WB_ADDR_W-1:ADDR_W];

  assign wbs_stall = (state != ST_RUN) | (pending == PEND_W'(MAX_OUTSTANDING));
  assign accept    = wbs_cycle & wbs_strobe & ~wbs_stall & ~reset;

  // One phase counter serves init, run and refresh; it restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      phase_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (phase_cnt == INIT_LAST) begin
            state     <= ST_RUN;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        ST_RUN: begin
          if (REFRESH_PERIOD == 0) begin
            phase_cnt <= '0;
          end else if (phase_cnt == RUN_LAST) begin
            state     <= ST_REFRESH;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        ST_REFRESH: begin
          if (phase_cnt == REF_LAST) begin
            state     <= ST_RUN;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        default: begin
          state     <= ST_INIT;
          phase_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else if (!wbs_cycle) begin
      pending <= '0;
    end else if (accept && !wbs_ack) begin
      pending <= pending + PEND_W'(1);
    end else if (!accept && wbs_ack) begin
      pending <= pending - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      protocol_err <= 1'b0;
    end else if (wbs_strobe && !wbs_cycle) begin
      protocol_err <= 1'b1;
    end
  end

  // RAM contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (accept && wbs_write) begin
      mem[idx] <= wbs_writedata;
    end
  end

  assign capture_data = (accept && !wbs_write) ? mem[idx] : '0;

  wbs_sdram_model_ack_pipe #(
    .LATENCY (LATENCY),
    .DATA_W  (WB_DATA_W)
  ) u_ack_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (~wbs_cycle),
    .in_valid  (accept),
    .in_data   (capture_data),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  assign wbs_ack      = pipe_valid & wbs_cycle;
  assign wbs_readdata = wbs_ack ? pipe_data : '0;

endmodule
